// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types, widths and byte-lane helpers for the IF/MEM RAM arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned LANE_W = 2;

    // Access length codes carried on mem_len
    localparam logic [LEN_W-1:0] LEN_BYTE = 2'b00;
    localparam logic [LEN_W-1:0] LEN_HALF = 2'b01;
    localparam logic [LEN_W-1:0] LEN_WORD = 2'b10;

    // Instruction fetches always move a full word
    localparam logic [CNT_W-1:0] IF_BYTES = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_e;

    // Byte count of a MEM access; the reserved code 11 behaves as a word
    function automatic logic [CNT_W-1:0] len_to_bytes(input logic [LEN_W-1:0] len);
        logic [CNT_W-1:0] n;
        case (len)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    // Extract little-endian byte lane idx of a word
    function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] word,
                                                   input logic [LANE_W-1:0] idx);
        return word[{idx, 3'b000} +: BYTE_W];
    endfunction

    // Replace little-endian byte lane idx of a word
    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] word,
                                                   input logic [LANE_W-1:0] idx,
                                                   input logic [BYTE_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = word;
        r[{idx, 3'b000} +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide, 1-cycle-latency RAM between instruction fetch and load/store.
// Word fetches and 1/2/4-byte loads/stores are serialised into byte transfers and reassembled.
// Build option MEM_ARB_FAIR_EN: alternate priority after each contended grant (default: MEM always wins).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    nbytes_q, nbytes_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_wr_q, ram_wr_d;
    logic [BYTE_W-1:0]   ram_dout_q, ram_dout_d;
    logic                if_done_q, if_done_d;
    logic [DATA_W-1:0]   if_inst_q, if_inst_d;
    logic                mem_done_q, mem_done_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
`ifdef MEM_ARB_FAIR_EN
    logic                prio_if_q, prio_if_d;
`endif

    logic                grant_mem;
    logic                grant_if;
    logic                if_ok;
    logic [CNT_W-1:0]    cnt_inc;
    logic [DATA_W-1:0]   asm_upd;

    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_done   = if_done_q;
    assign if_inst   = if_inst_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

    // Arbitration between the two requesters; only meaningful while idle
    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if_ok     = if_req && !flush;
`ifdef MEM_ARB_FAIR_EN
        prio_if_d = prio_if_q;
        if (state_q == ST_IDLE) begin
            if (mem_req && if_ok) begin
                grant_if  = prio_if_q;
                grant_mem = !prio_if_q;
                prio_if_d = !prio_if_q;
            end else begin
                grant_mem = mem_req;
                grant_if  = if_ok;
            end
        end
`else
        if (state_q == ST_IDLE) begin
            grant_mem = mem_req;
            grant_if  = if_ok && !mem_req;
        end
`endif
    end

    // Byte sequencing, lane assembly and registered output updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        if_inst_d   = if_inst_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;

        cnt_inc = CNT_W'(cnt_q + CNT_W'(1));
        // Byte returned now belongs to the address issued one cycle earlier
        asm_upd = put_byte(asm_q, LANE_W'(cnt_q - CNT_W'(1)), ram_din);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (grant_mem) begin
                    nbytes_d   = len_to_bytes(mem_len);
                    wdata_d    = mem_wdata;
                    asm_d      = '0;
                    ram_addr_d = mem_addr;
                    if (mem_we) begin
                        state_d    = ST_MEM_WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = get_byte(mem_wdata, LANE_W'(0));
                    end else begin
                        state_d = ST_MEM_RD;
                    end
                end else if (grant_if) begin
                    state_d    = ST_IF_RD;
                    nbytes_d   = IF_BYTES;
                    asm_d      = '0;
                    ram_addr_d = if_addr;
                end
            end

            ST_IF_RD, ST_MEM_RD: begin
                if (state_q == ST_IF_RD && flush) begin
                    // Mispredicted fetch: drop partial bytes, keep last if_inst
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != '0) begin
                        asm_d = asm_upd;
                    end
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        if (state_q == ST_IF_RD) begin
                            if_done_d = 1'b1;
                            if_inst_d = asm_upd;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = asm_upd;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc < nbytes_q) begin
                            ram_addr_d = ADDR_W'(ram_addr_q + ADDR_W'(1));
                        end
                    end
                end
            end

            ST_MEM_WR: begin
                if (cnt_inc < nbytes_q) begin
                    cnt_d      = cnt_inc;
                    ram_addr_d = ADDR_W'(ram_addr_q + ADDR_W'(1));
                    ram_wr_d   = 1'b1;
                    ram_dout_d = get_byte(wdata_q, LANE_W'(cnt_inc));
                end else begin
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end
            end

            ST_DONE: begin
                // Requester sees its done pulse here and retires its request
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_done_q   <= 1'b0;
            if_inst_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
`ifdef MEM_ARB_FAIR_EN
            prio_if_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            if_inst_q   <= if_inst_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_FAIR_EN
            prio_if_q   <= prio_if_d;
`endif
        end
    end

endmodule
